// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
// Output-side audio serializer for the filter datapath. Mono Q15 samples
// enter through a valid/ready handshake into a 2-entry FIFO. One sample is
// popped per frame and shifted MSB-first onto sdata in both the left and
// the right slot.
//
// Parameters:
//   CLK_DIV   - clk cycles per half period of bclk (>= 1)
//   SLOT_BITS - bclk periods per channel slot (17..32)
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-high
//   sample_in    - signed Q15 sample
//   sample_valid - sample_in is valid
//   sample_ready - FIFO can accept a sample
//   bclk         - serial bit clock (registered)
//   lrck         - 0 = left slot, 1 = right slot (registered)
//   sdata        - serial data, MSB first (registered)
//   underrun     - one-clk pulse when a frame starts with the FIFO empty
// Build option:
//   I2S_DELAY_EN - defined: I2S format (MSB one bclk after the lrck edge);
//                  undefined: left-justified (MSB on the lrck edge)
module audio_dac_serializer #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        underrun
);

    localparam int PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BW         = $clog2(FRAME_BITS);

    logic [PW-1:0] pre;
    logic [BW-1:0] bit_cnt;
    logic [15:0]   fifo_mem [2];
    logic [1:0]    count;
    logic [15:0]   frame_sample;

    logic          pre_tc;
    logic          bit_tick;
    logic          frame_start;
    logic          push;
    logic          pop;
    logic [BW-1:0] bit_cnt_nxt;
    logic [BW-1:0] slot_pos;
    logic [15:0]   data_sample;
    logic          in_data;
    logic [3:0]    bit_idx;
    logic          sdata_nxt;

    assign sample_ready = (count < 2'd2);
    assign push         = sample_valid & sample_ready;

    // A bit tick is the prescaler wrap that takes bclk from 1 to 0.
    assign pre_tc      = (pre == PW'(CLK_DIV - 1));
    assign bit_tick    = pre_tc & bclk;
    assign bit_cnt_nxt = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign frame_start = bit_tick & (bit_cnt_nxt == '0);
    assign pop         = frame_start & (count != 2'd0);

    // sdata is computed from the post-tick bit position so that data, lrck
    // and the popped sample all change on the same clk edge.
    always_comb begin
        slot_pos = bit_cnt_nxt;
        if (bit_cnt_nxt >= BW'(SLOT_BITS))
            slot_pos = bit_cnt_nxt - BW'(SLOT_BITS);
        data_sample = frame_sample;
        if (frame_start)
            data_sample = (count != 2'd0) ? fifo_mem[0] : '0;
`ifdef I2S_DELAY_EN
        in_data = (slot_pos != '0) && (slot_pos <= BW'(16));
        bit_idx = 4'(BW'(16) - slot_pos);
`else
        in_data = (slot_pos < BW'(16));
        bit_idx = 4'(BW'(15) - slot_pos);
`endif
        sdata_nxt = in_data ? data_sample[bit_idx] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre          <= '0;
            bclk         <= 1'b0;
            bit_cnt      <= BW'(FRAME_BITS - 1);
            lrck         <= 1'b1;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
            frame_sample <= '0;
        end else begin
            underrun <= 1'b0;
            if (pre_tc) begin
                pre  <= '0;
                bclk <= ~bclk;
            end else begin
                pre <= pre + 1'b1;
            end
            if (bit_tick) begin
                bit_cnt <= bit_cnt_nxt;
                lrck    <= (bit_cnt_nxt >= BW'(SLOT_BITS));
                sdata   <= sdata_nxt;
                if (frame_start) begin
                    frame_sample <= data_sample;
                    underrun     <= (count == 2'd0);
                end
            end
        end
    end

    // Head is always fifo_mem[0]; a pop shifts entry 1 down. On a
    // simultaneous push/pop (count is necessarily 1) the new sample
    // replaces the head in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            case ({push, pop})
                2'b11: fifo_mem[0] <= sample_in;
                2'b01: begin
                    fifo_mem[0] <= fifo_mem[1];
                    count       <= count - 2'd1;
                end
                2'b10: begin
                    fifo_mem[count[0]] <= sample_in;
                    count              <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Output-side audio serializer for the filter datapath. Accepts signed 16-bit Q15 samples, such as the FIR filter output, through a valid/ready handshake and buffers them in a 2-entry FIFO. Generates the bit clock and LR clock from `clk`, and shifts each sample MSB-first onto a serial data line for the codec DAC. The same mono sample is sent on both the left and the right channel.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per half period of `bclk`; legal range is 1 or more.
- `SLOT_BITS`, default 32: `bclk` periods per channel slot; legal range is 17–32.
- `clk` in, 1 bit: system clock; every register is clocked on its rising edge.
- `reset` in, 1 bit: asynchronous, active-high.
- `sample_in` in, 16 bits: signed sample (Q15).
- `sample_valid` in, 1 bit: `sample_in` holds a valid sample.
- `sample_ready` out, 1 bit: the FIFO can accept a sample.
- `bclk` out, 1 bit: serial bit clock (registered).
- `lrck` out, 1 bit: 0 selects the left slot, 1 selects the right slot (registered).
- `sdata` out, 1 bit: serial data, MSB first (registered).
- `underrun` out, 1 bit: one-`clk` pulse when a frame starts with the FIFO empty.

## Operation
- **FIFO**
  - 2 entries, 16 bits wide.
  - `sample_ready` = (count < 2), derived combinationally from the count register.
  - A push happens on a `clk` edge where `sample_valid && sample_ready`.
- **Prescaler**
  - Counts from 0 to `CLK_DIV`-1.
  - At terminal count it wraps to 0 and toggles `bclk`.
  - A toggle from 1 to 0 is a *bit tick*.
- **Bit counter `bit_cnt`**
  - Range is 0 to 2·`SLOT_BITS`-1.
  - Increments on each bit tick and wraps to 0; the tick that produces `bit_cnt` = 0 is a *frame start*.
  - `lrck` = (`bit_cnt` ≥ `SLOT_BITS`), registered and updated on the bit tick.
- **Frame start**
  - If the FIFO is non-empty: pop the head into `frame_sample`.
  - If the FIFO is empty: load `frame_sample` = 0 and pulse `underrun` for one `clk`.
- **Data placement**
  - Slot position p = `bit_cnt` mod `SLOT_BITS`.
  - Data offset d = 0, or d = 1 when `I2S_DELAY_EN` is defined (see Configuration).
  - For d ≤ p < d+16: `sdata` = `frame_sample`[15-(p-d)]. Otherwise `sdata` = 0.
  - Both slots carry the same `frame_sample`.
- **Simultaneous push and pop**
  - Count is 1: both take effect and the count stays 1; the pop takes the older entry.
  - Count is 0: the pop sees empty (underrun, zero frame) and the push is stored; there is no bypass.
  - Count is 2: `sample_ready` is 0, so only the pop occurs.
- **Reset** (asynchronous, including mid-frame):
  - FIFO is emptied.
  - Prescaler = 0, `bit_cnt` = 2·`SLOT_BITS`-1, `frame_sample` = 0.
  - Outputs: `bclk` = 0, `lrck` = 1, `sdata` = 0, `underrun` = 0, `sample_ready` = 1.
  - The first frame starts on the first bit tick after reset release.

## Timing
- `bclk` period is 2·`CLK_DIV` `clk` cycles.
- After reset release, the first `bclk` rise occurs at `clk` edge `CLK_DIV`.
- The first bit tick (frame start) occurs at `clk` edge 2·`CLK_DIV`.
- Frame length is 2·`SLOT_BITS` `bclk` periods, i.e. 4·`CLK_DIV`·`SLOT_BITS` `clk` cycles (512 at defaults).
- `bclk`, `lrck`, `sdata`, the FIFO pop and `underrun` all update on the same `clk` edge as the bit tick.
- Data changes on the falling edge of `bclk`; the DAC samples on the rising edge.
- Latency:
  - A sample pushed into an empty FIFO leaves as MSB on `sdata` at the next frame start (no I2S delay) or one `bclk` later (with I2S delay).
  - A queued sample waits one additional frame per entry ahead of it.
- Throughput: exactly one sample consumed per frame.

## Configuration
- Macro: `I2S_DELAY_EN`.
- **Defined:** I2S format. The MSB appears one `bclk` period after each `lrck` edge (d = 1).
- **Undefined:** left-justified format. The MSB coincides with the `lrck` edge (d = 0).
- The following are identical in both modes: `lrck` timing, FIFO behaviour, pop instant and `underrun`.

## Test plan
All scenarios use `CLK_DIV`=2 and `SLOT_BITS`=32.

1. **Reset values and clocking.** Apply reset, then release it.
   - `bclk` has a 4-`clk` period; `lrck` falls at `clk` edge 4 and toggles every 128 `clk`.
   - `sample_ready` = 1; during reset `lrck` = 1 and `bclk` = `sdata` = `underrun` = 0.
2. **Single sample.** Push 0x8001 before the first frame start.
   - Left slot reads 1, fourteen 0s, 1, then 16 zeros; the right slot repeats this.
   - `underrun` stays 0 for that frame.
3. **Underrun.** Push nothing.
   - `sdata` stays 0.
   - `underrun` pulses for exactly one `clk` at every frame start (every 256 `clk`).
4. **Backpressure.** Hold `sample_valid` with values 0x1234, 0x5678, 0x9ABC.
   - The first two are accepted on consecutive cycles, then `sample_ready` = 0.
   - 0x9ABC is accepted on the `clk` edge after the frame start that pops 0x1234.
   - Output order is 0x1234, 0x5678, 0x9ABC.
5. **Reset mid-frame.** Assert `reset` at bit 10 of a left slot while the FIFO holds 2 entries.
   - Outputs return to their reset values immediately and `sample_ready` = 1.
   - After release, the first frame underruns.
6. **I2S delay.** With `I2S_DELAY_EN` defined, push 0xC000.
   - `sdata` = 0 at slot bit 0, and 1 at slot bits 1 and 2, in both slots.
   - All other bits are 0.
